// File: rtl/logic_noise_pkg.sv
// Shared types for the logic-noise voice blocks.
// Holds the sequencer transport state encoding.
package logic_noise_pkg;

   typedef enum logic [1:0] {
      STOPPED = 2'd0,
      RUNNING = 2'd1,
      PAUSED  = 2'd2
   } seq_state_t;

endpackage

// File: rtl/loop_sequencer_tempo_divider.sv
// Tempo divider: counts clocks within a step and flags the step boundary.
// The period is re-latched only at a wrap or a restart, so edits apply from the next step.
module tempo_divider #(
   parameter int DIVW = 24
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            en,
   input  logic            restart,
   input  logic [DIVW-1:0] tempo_top,
   output logic [DIVW-1:0] div_cnt,
   output logic            tick
);

   logic [DIVW-1:0] tempo_top_lat;

   // >= rather than == so a shortened period can never force a full counter wrap-around.
   assign tick = en & ~restart & (div_cnt >= tempo_top_lat);

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         div_cnt       <= '0;
         tempo_top_lat <= '0;
      end else if (restart) begin
         div_cnt       <= '0;
         tempo_top_lat <= tempo_top;
      end else if (en) begin
         if (tick) begin
            div_cnt       <= '0;
            tempo_top_lat <= tempo_top;
         end else begin
            div_cnt <= div_cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/loop_sequencer.sv
// Step sequencer: transport FSM, editable WIDTH-step pattern and per-step note gate.
// The gate is ANDed with the oscillator upstream to form pwmout.
module loop_sequencer
   import logic_noise_pkg::*;
#(
   parameter int               WIDTH        = 16,
   parameter int               DIVW         = 24,
   parameter logic [WIDTH-1:0] INIT_PATTERN = '0,
   localparam int              SW           = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [DIVW-1:0]  tempo_top,
   input  logic [DIVW-1:0]  gate_len,
   input  logic             start,
   input  logic             pause,
   input  logic             stop,
   input  logic             set,
   input  logic             clear,
   output logic [WIDTH-1:0] pattern_out,
   output logic [SW-1:0]    step,
   output logic             step_tick,
   output logic             running,
   output logic             gate
);

   seq_state_t      state;
   logic [DIVW-1:0] div_cnt;
   logic            div_tick;
   logic            do_restart;
   logic            div_en;

   // Start from STOPPED or RUNNING rewinds to step 0; from PAUSED it only resumes.
   assign do_restart = start & ~stop & (state != PAUSED);
   assign div_en     = (state == RUNNING) & ~stop & ~start & ~pause;

   tempo_divider #(.DIVW(DIVW)) u_div (
      .clk       (clk),
      .rst       (rst),
      .en        (div_en),
      .restart   (stop | do_restart),
      .tempo_top (tempo_top),
      .div_cnt   (div_cnt),
      .tick      (div_tick)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= STOPPED;
         step        <= '0;
         step_tick   <= 1'b0;
         running     <= 1'b0;
         // NOTE: the pattern is a plain register bank, so it is reset like any other state.
         pattern_out <= INIT_PATTERN;
      end else begin
         step_tick <= do_restart | div_tick;

         if (stop) begin
            state   <= STOPPED;
            running <= 1'b0;
            step    <= '0;
         end else if (start) begin
            state   <= RUNNING;
            running <= 1'b1;
            if (state != PAUSED) step <= '0;
         end else if (pause && state == RUNNING) begin
            state   <= PAUSED;
            running <= 1'b0;
         end else if (div_tick) begin
            step <= step + 1'b1;
         end

         // Edits target the step as registered this cycle, even while it advances.
         if (clear)    pattern_out[step] <= 1'b0;
         else if (set) pattern_out[step] <= 1'b1;
      end
   end

   assign gate = running & pattern_out[step] & (div_cnt < gate_len);

endmodule

// File: tb/tb_loop_sequencer.sv
// Directed bench for loop_sequencer: transport, gate shaping, edits and async reset.
// Inputs change just after the falling edge; outputs are sampled on the falling edge.
module tb_loop_sequencer;

   localparam int WIDTH = 16;
   localparam int DIVW  = 24;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [DIVW-1:0]  tempo_top = '0;
   logic [DIVW-1:0]  gate_len = '0;
   logic             start = 1'b0;
   logic             pause = 1'b0;
   logic             stop = 1'b0;
   logic             set = 1'b0;
   logic             clear = 1'b0;
   logic [WIDTH-1:0] pattern_out;
   logic [3:0]       step;
   logic             step_tick;
   logic             running;
   logic             gate;

   int n_tests = 0;
   int n_fail  = 0;

   loop_sequencer #(
      .WIDTH        (WIDTH),
      .DIVW         (DIVW),
      .INIT_PATTERN (16'h8001)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .tempo_top   (tempo_top),
      .gate_len    (gate_len),
      .start       (start),
      .pause       (pause),
      .stop        (stop),
      .set         (set),
      .clear       (clear),
      .pattern_out (pattern_out),
      .step        (step),
      .step_tick   (step_tick),
      .running     (running),
      .gate        (gate)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic run(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse_start();
      start = 1'b1; run(1); start = 1'b0;
   endtask

   task automatic pulse_stop();
      stop = 1'b1; run(1); stop = 1'b0;
   endtask

   initial begin
      int s;
      tempo_top = 24'd3;
      gate_len  = 24'd4;
      #1 rst = 1'b0;
      run(2);
      check("rst_step", 32'(step), 32'd0);
      check("rst_tick", 32'(step_tick), 32'd0);
      check("rst_running", 32'(running), 32'd0);
      check("rst_gate", 32'(gate), 32'd0);
      check("rst_pattern", 32'(pattern_out), 32'h8001);
      rst = 1'b1;
      run(1);

      // Full loop at tempo 3: tick every 4 clocks, gate only on steps 0 and 15.
      pulse_start();
      check("t1_running", 32'(running), 32'd1);
      for (int i = 0; i < 68; i++) begin
         s = (i / 4) % 16;
         check("t1_step", 32'(step), 32'(s));
         check("t1_tick", 32'(step_tick), (i % 4 == 0) ? 32'd1 : 32'd0);
         check("t1_gate", 32'(gate), (s == 0 || s == 15) ? 32'd1 : 32'd0);
         run(1);
      end
      pulse_stop();
      check("t1_stopped", 32'(running), 32'd0);

      // tempo_top=0: advance every clock with step_tick held high; fill the pattern.
      tempo_top = 24'd0;
      pulse_start();
      set = 1'b1;
      for (int i = 0; i < 16; i++) begin
         check("t0_step", 32'(step), 32'(i));
         check("t0_tick", 32'(step_tick), 32'd1);
         run(1);
      end
      set = 1'b0;
      pulse_stop();
      check("fill_pattern", 32'(pattern_out), 32'hffff);

      // Gate length shaping, then legato.
      tempo_top = 24'd3;
      gate_len  = 24'd2;
      pulse_start();
      for (int i = 0; i < 8; i++) begin
         check("t2_gate_len2", 32'(gate), (i % 4 < 2) ? 32'd1 : 32'd0);
         run(1);
      end
      gate_len = 24'd8;
      for (int i = 0; i < 8; i++) begin
         check("t2_legato", 32'(gate), 32'd1);
         run(1);
      end

      // Pause at step 5 / div_cnt 2, hold, then resume.
      run(6);
      check("t3_pre_step", 32'(step), 32'd5);
      pause = 1'b1; run(1); pause = 1'b0;
      for (int i = 0; i < 10; i++) begin
         check("t3_p_running", 32'(running), 32'd0);
         check("t3_p_step", 32'(step), 32'd5);
         check("t3_p_tick", 32'(step_tick), 32'd0);
         check("t3_p_gate", 32'(gate), 32'd0);
         run(1);
      end
      pulse_start();
      check("t3_r_running", 32'(running), 32'd1);
      check("t3_r_step", 32'(step), 32'd5);
      check("t3_r_tick", 32'(step_tick), 32'd0);
      check("t3_r_gate", 32'(gate), 32'd1);
      run(1);
      check("t3_r_step1", 32'(step), 32'd5);
      check("t3_r_tick1", 32'(step_tick), 32'd0);
      run(1);
      check("t3_wrap_step", 32'(step), 32'd6);
      check("t3_wrap_tick", 32'(step_tick), 32'd1);

      // stop and start together at step 7: stop wins.
      run(4);
      check("t5_pre_step", 32'(step), 32'd7);
      stop = 1'b1; start = 1'b1; run(1); stop = 1'b0; start = 1'b0;
      check("t5_running", 32'(running), 32'd0);
      check("t5_step", 32'(step), 32'd0);
      check("t5_tick", 32'(step_tick), 32'd0);
      check("t5_gate", 32'(gate), 32'd0);
      run(3);
      check("t5_hold_step", 32'(step), 32'd0);
      check("t5_hold_tick", 32'(step_tick), 32'd0);
      check("t5_hold_running", 32'(running), 32'd0);

      // Edits while stopped at step 0; clear beats set.
      clear = 1'b1; run(1); clear = 1'b0;
      check("t4_clear", 32'(pattern_out), 32'hfffe);
      set = 1'b1; run(1); set = 1'b0;
      check("t4_set", 32'(pattern_out), 32'hffff);
      set = 1'b1; clear = 1'b1; run(1); set = 1'b0; clear = 1'b0;
      check("t4_set_clear", 32'(pattern_out), 32'hfffe);

      // Edits on an advancing cycle hit the old step.
      pulse_start();
      run(3);
      set = 1'b1; run(1); set = 1'b0;
      check("t4_adv_set", 32'(pattern_out), 32'hffff);
      check("t4_adv_set_step", 32'(step), 32'd1);
      run(7);
      check("t4_pre_clear_step", 32'(step), 32'd2);
      clear = 1'b1; run(1); clear = 1'b0;
      check("t4_adv_clear", 32'(pattern_out), 32'hfffb);
      check("t4_adv_clear_step", 32'(step), 32'd3);
      pulse_stop();

      // Asynchronous reset mid-step at step 9 with the gate open.
      gate_len = 24'd4;
      pulse_start();
      run(37);
      check("t6_pre_step", 32'(step), 32'd9);
      check("t6_pre_gate", 32'(gate), 32'd1);
      #2 rst = 1'b0;
      #1;
      check("t6_step", 32'(step), 32'd0);
      check("t6_running", 32'(running), 32'd0);
      check("t6_gate", 32'(gate), 32'd0);
      check("t6_tick", 32'(step_tick), 32'd0);
      check("t6_pattern", 32'(pattern_out), 32'h8001);
      run(1);
      rst = 1'b1;
      run(3);
      check("t6_post_running", 32'(running), 32'd0);
      check("t6_post_step", 32'(step), 32'd0);
      check("t6_post_tick", 32'(step_tick), 32'd0);
      pulse_start();
      check("t6_restart_tick", 32'(step_tick), 32'd1);
      check("t6_restart_running", 32'(running), 32'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
